// File: rtl/tdm_mux.sv
// tdm_mux: registered N-channel multiplexer with manual select and time-division scan.
// Define TDM_MUX_SKIP_EN to add a MASK input that limits which channels the scan visits.
module tdm_mux #(
  parameter int WIDTH   = 4,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [(2**SEL_W)*WIDTH-1:0]     X,
  input  logic [SEL_W-1:0]                S,
  input  logic                            MODE,
  input  logic                            EN,
  input  logic [DWELL_W-1:0]              DWELL,
`ifdef TDM_MUX_SKIP_EN
  input  logic [(2**SEL_W)-1:0]           MASK,
`endif
  output logic [WIDTH-1:0]                Y,
  output logic [SEL_W-1:0]                CH,
  output logic                            VALID,
  output logic                            WRAP
);

  localparam int CHANNELS = 2**SEL_W;

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t               state_q;
  logic [SEL_W-1:0]     ch_q;
  logic [WIDTH-1:0]     y_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic                 valid_q;
  logic                 wrap_q;

  logic [WIDTH-1:0]     chData [CHANNELS];

  logic [SEL_W-1:0]     advCh_d;
  logic                 advValid_d;
  logic                 advWrap_d;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign chData[k] = X[k*WIDTH +: WIDTH];
  end

`ifdef TDM_MUX_SKIP_EN
  // Walk offsets from the far end back toward CH+1 so the nearest enabled channel wins;
  // offset CHANNELS lands on CH itself, covering the single-enabled-channel case.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand       = ch_q;
    advCh_d    = ch_q;
    advValid_d = 1'b0;
    advWrap_d  = 1'b0;
    for (int k = CHANNELS; k >= 1; k--) begin
      cand = ch_q + SEL_W'(k);
      if (MASK[cand]) begin
        advCh_d    = cand;
        advValid_d = 1'b1;
      end
    end
    advWrap_d = advValid_d && (advCh_d <= ch_q);
  end
`else
  always_comb begin
    advCh_d    = ch_q + SEL_W'(1);
    advValid_d = 1'b1;
    advWrap_d  = (ch_q == '1);
  end
`endif

  // Mode/scan FSM; every output is registered here so inputs never reach outputs combinationally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= MANUAL;
      ch_q    <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (!EN) begin
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (!MODE) begin
      state_q <= MANUAL;
      ch_q    <= S;
      y_q     <= chData[S];
      cnt_q   <= '0;
      valid_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else if (state_q == MANUAL) begin
      state_q <= SCAN;
      ch_q    <= S;
      y_q     <= chData[S];
      cnt_q   <= '0;
      valid_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else if (cnt_q >= DWELL) begin
      ch_q    <= advCh_d;
      y_q     <= chData[advCh_d];
      cnt_q   <= '0;
      valid_q <= advValid_d;
      wrap_q  <= advWrap_d;
    end else begin
      cnt_q   <= cnt_q + DWELL_W'(1);
      y_q     <= chData[ch_q];
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end
  end

  assign Y     = y_q;
  assign CH    = ch_q;
  assign VALID = valid_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_tdm_mux.sv
// Directed testbench for tdm_mux: expected outputs are queued as each step is driven
// and popped one cycle later when the registered outputs settle.
module tb_tdm_mux;

  localparam int WIDTH   = 4;
  localparam int SEL_W   = 2;
  localparam int DWELL_W = 4;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [4*WIDTH-1:0]    X;
  logic [SEL_W-1:0]      S;
  logic                  MODE;
  logic                  EN;
  logic [DWELL_W-1:0]    DWELL;
  logic [3:0]            MASK;
  logic [WIDTH-1:0]      Y;
  logic [SEL_W-1:0]      CH;
  logic                  VALID;
  logic                  WRAP;

  typedef struct {
    string      tag;
    logic [3:0] y;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t sbQueue [$];
  int   passCount  = 0;
  int   failCount  = 0;
  int   totalCount = 0;

  always #5 CLK = ~CLK;

  tdm_mux #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .X     (X),
    .S     (S),
    .MODE  (MODE),
    .EN    (EN),
    .DWELL (DWELL),
`ifdef TDM_MUX_SKIP_EN
    .MASK  (MASK),
`endif
    .Y     (Y),
    .CH    (CH),
    .VALID (VALID),
    .WRAP  (WRAP)
  );

  task automatic compareField(input string tag, input string field,
                              input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, observed, expected);
    end
  endtask

  // Pops the oldest expectation and compares it with what the DUT registered.
  task automatic checkOutput();
    exp_t e;
    if (sbQueue.size() == 0) begin
      compareField("scoreboard", "empty", 32'd1, 32'd0);
    end else begin
      e = sbQueue.pop_front();
      compareField(e.tag, "Y",     32'(Y),     32'(e.y));
      compareField(e.tag, "CH",    32'(CH),    32'(e.ch));
      compareField(e.tag, "VALID", 32'(VALID), 32'(e.valid));
      compareField(e.tag, "WRAP",  32'(WRAP),  32'(e.wrap));
    end
  endtask

  // Inputs are already set; queue the expectation, clock once, then check just after the edge.
  task automatic applyStimulus(input string tag, input logic [3:0] y, input logic [1:0] ch,
                               input logic valid, input logic wrap);
    exp_t e;
    e.tag = tag; e.y = y; e.ch = ch; e.valid = valid; e.wrap = wrap;
    sbQueue.push_back(e);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  initial begin
    $display("[TB] tdm_mux directed test starting");
    X     = {4'hD, 4'hC, 4'hB, 4'hA};
    S     = 2'd0;
    MODE  = 1'b1;
    EN    = 1'b1;
    DWELL = 4'd0;
    MASK  = 4'b1111;
    RST   = 1'b1;

    applyStimulus("rst0", 4'h0, 2'd0, 1'b0, 1'b0);
    applyStimulus("rst1", 4'h0, 2'd0, 1'b0, 1'b0);

    RST = 1'b0; S = 2'd1;
    applyStimulus("entryAfterRst", 4'hB, 2'd1, 1'b1, 1'b0);

    MODE = 1'b0; S = 2'd2;
    applyStimulus("manS2", 4'hC, 2'd2, 1'b1, 1'b0);
    S = 2'd0;
    applyStimulus("manS0", 4'hA, 2'd0, 1'b1, 1'b0);
    X[3:0] = 4'h5;
    applyStimulus("manLiveX", 4'h5, 2'd0, 1'b1, 1'b0);
    X[3:0] = 4'hA;

    MODE = 1'b1; S = 2'd1; DWELL = 4'd0;
    applyStimulus("scan0Entry", 4'hB, 2'd1, 1'b1, 1'b0);
    applyStimulus("scan0Ch2",   4'hC, 2'd2, 1'b1, 1'b0);
    applyStimulus("scan0Ch3",   4'hD, 2'd3, 1'b1, 1'b0);
    applyStimulus("scan0Wrap",  4'hA, 2'd0, 1'b1, 1'b1);
    applyStimulus("scan0Ch1",   4'hB, 2'd1, 1'b1, 1'b0);

    MODE = 1'b0; S = 2'd1;
    applyStimulus("toManual", 4'hB, 2'd1, 1'b1, 1'b0);
    MODE = 1'b1; DWELL = 4'd2;
    applyStimulus("scan2Entry", 4'hB, 2'd1, 1'b1, 1'b0);
    applyStimulus("scan2Dw1",   4'hB, 2'd1, 1'b0, 1'b0);
    applyStimulus("scan2Dw2",   4'hB, 2'd1, 1'b0, 1'b0);
    applyStimulus("scan2Adv",   4'hC, 2'd2, 1'b1, 1'b0);
    X[11:8] = 4'h7;
    applyStimulus("scan2LiveX", 4'h7, 2'd2, 1'b0, 1'b0);
    X[11:8] = 4'hC;
    applyStimulus("scan2Dw2b",  4'hC, 2'd2, 1'b0, 1'b0);
    applyStimulus("scan2Adv3",  4'hD, 2'd3, 1'b1, 1'b0);
    applyStimulus("scan2Cnt1",  4'hD, 2'd3, 1'b0, 1'b0);

    EN = 1'b0; X[15:12] = 4'hE;
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("freeze%0d", i), 4'hD, 2'd3, 1'b0, 1'b0);
    end
    EN = 1'b1; X[15:12] = 4'hD;
    applyStimulus("resumeDw",   4'hD, 2'd3, 1'b0, 1'b0);
    applyStimulus("resumeWrap", 4'hA, 2'd0, 1'b1, 1'b1);

    RST = 1'b1;
    applyStimulus("midRst", 4'h0, 2'd0, 1'b0, 1'b0);
    RST = 1'b0; S = 2'd2; DWELL = 4'd0;
    applyStimulus("reEntry", 4'hC, 2'd2, 1'b1, 1'b0);
    applyStimulus("reAdv",   4'hD, 2'd3, 1'b1, 1'b0);

`ifdef TDM_MUX_SKIP_EN
    MODE = 1'b0; S = 2'd0; MASK = 4'b1010;
    applyStimulus("skipMan",   4'hA, 2'd0, 1'b1, 1'b0);
    MODE = 1'b1;
    applyStimulus("skipEntry", 4'hA, 2'd0, 1'b1, 1'b0);
    applyStimulus("skipCh1",   4'hB, 2'd1, 1'b1, 1'b0);
    applyStimulus("skipCh3",   4'hD, 2'd3, 1'b1, 1'b0);
    applyStimulus("skipWrap1", 4'hB, 2'd1, 1'b1, 1'b1);
    applyStimulus("skipCh3b",  4'hD, 2'd3, 1'b1, 1'b0);
    MASK = 4'b0000;
    applyStimulus("skipNone",  4'hD, 2'd3, 1'b0, 1'b0);
    MASK = 4'b1000;
    applyStimulus("skipSelf",  4'hD, 2'd3, 1'b1, 1'b1);
`endif

    if (sbQueue.size() != 0) compareField("scoreboard", "leftover", 32'(sbQueue.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/tdm_mux.md
Name: tdm_mux

Overview:
- Parametrised, registered N-channel, WIDTH-bit multiplexer; the sequential successor to the team's combinational mux2/mux4 tree.
- Two modes:
  - Manual: channel chosen by S.
  - Scan: time-division, auto-advancing through channels with a programmable dwell time.
- Feeds downstream sampling/display logic with a registered output, the current channel index and per-sample strobes.

Parameters:
- WIDTH, 4, bits per channel.
- SEL_W, 2, select width; CHANNELS = 2**SEL_W (legal SEL_W 1..4).
- DWELL_W, 4, width of dwell count.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- X  input  CHANNELS*WIDTH  packed channel data; channel k = X[k*WIDTH +: WIDTH].
- S  input  SEL_W  manual select; also the start channel on scan entry.
- MODE  input  1  0 = manual, 1 = scan.
- EN  input  1  clock enable; 0 freezes all state.
- DWELL  input  DWELL_W  extra cycles to stay on each channel in scan mode (0 = advance every enabled cycle).
- Y  output  WIDTH  registered selected data.
- CH  output  SEL_W  channel currently driving Y.
- VALID  output  1  1-cycle strobe: Y holds a newly selected channel.
- WRAP  output  1  1-cycle strobe: scan wrapped from the last channel back to channel 0.

Behaviour:
- Reset (RST=1 at edge, overrides EN/MODE): Y=0, CH=0, VALID=0, WRAP=0, internal cnt=0, internal state=MANUAL.
- States: MANUAL, SCAN. Transitions are taken only on enabled cycles:
  - MODE=1 moves to SCAN.
  - MODE=0 moves to MANUAL.
- EN=0: Y, CH, cnt and state hold; VALID=0, WRAP=0.
- EN=1, MODE=0: CH<=S, Y<=X[S], VALID<=1, WRAP<=0, cnt<=0. Latency 1 cycle, every cycle (S changes visible next cycle).
- EN=1, MODE=1, state=MANUAL (scan entry, including the first enabled cycle after reset): CH<=S, Y<=X[S], cnt<=0, VALID<=1, WRAP<=0; state<=SCAN.
- EN=1, MODE=1, state=SCAN, cnt>=DWELL (advance): nxt=(CH+1) mod CHANNELS; CH<=nxt, Y<=X[nxt], cnt<=0, VALID<=1, WRAP<=(CH==CHANNELS-1).
- EN=1, MODE=1, state=SCAN, cnt<DWELL (dwell): cnt<=cnt+1; Y<=X[CH] (tracks live data on the held channel); VALID<=0, WRAP<=0.
- DWELL is sampled every cycle. The >= compare makes lowering DWELL mid-dwell cause an advance on the next enabled cycle; no counter overflow is possible.
- MODE 1->0 mid-dwell: immediate manual selection next cycle; cnt cleared.
- Reset mid-scan: next cycle is the full reset state; the first enabled MODE=1 cycle after that is a scan entry from S.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: TDM_MUX_SKIP_EN.
- Defined:
  - Adds input MASK (CHANNELS bits, 1 = channel enabled for scanning).
  - Advance picks the next set MASK bit after CH, cyclically.
  - WRAP=1 when the chosen index <= CH (wrapped past top).
  - If MASK==0, advance holds CH and Y<=X[CH], VALID=0, cnt<=0.
  - If CH itself is the only set bit, CH is reselected with VALID=1 and WRAP=1.
  - Scan entry and manual mode ignore MASK.
- Undefined: no MASK port; all channels scanned as above.

Test Plan:
- Stimulus (common to all scenarios): WIDTH=4, SEL_W=2, X={4'hD,4'hC,4'hB,4'hA} (ch0=A .. ch3=D).
- Reset: EN=1, MODE=1, RST=1 for 2 cycles -> Y=0, CH=0, VALID=0, WRAP=0; first cycle after release with S=1 -> CH=1, Y=4'hB, VALID=1.
- Manual: MODE=0, EN=1, S=2 then S=0 -> Y=4'hC, CH=2, then Y=4'hA, CH=0, VALID=1 both cycles; changing X ch0 to 4'h5 -> Y=4'h5 next cycle.
- Scan DWELL=0 from S=1 -> CH sequence 1,2,3,0,1, Y=B,C,D,A,B, VALID=1 every cycle, WRAP=1 only on the cycle CH becomes 0.
- Scan DWELL=2 -> CH advances every 3rd cycle, VALID pattern 1,0,0,1,0,0; changing X[CH] mid-dwell appears on Y next cycle with VALID=0.
- EN=0 for 5 cycles mid-dwell (cnt=1, DWELL=2) -> CH/Y frozen, VALID=WRAP=0; after EN=1 the advance occurs after exactly 2 more cycles.
- With TDM_MUX_SKIP_EN, MASK=4'b1010, DWELL=0, entry S=0 -> CH 0,1,3,1,3; WRAP=1 on each 3->1 step; MASK=0 -> CH holds, VALID=0.
